hollywood_hash_search: RTL

HOLLYWOOD_HASH_SEARCH -- requirements
Module: hollywood_hash_search

---
 rtl/hollywood_hash_search.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hollywood_hash_search.sv
// Brute-force password search driving an external hash checker core.
// One candidate per CLEAR/SEND/WAIT/CHECK pass, range inclusive and wrapping.
module hollywood_hash_search #(
    parameter int unsigned LEN     = 2,
    parameter int unsigned HIT_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [16*LEN-1:0] start_value,
    input  logic [16*LEN-1:0] end_value,
    output logic              mgmt_valid,
    output logic [7:0]        mgmt_data,
    output logic              in_valid,
    output logic [15:0]       in_data,
    input  logic              hit_in,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [16*LEN-1:0] found_value,
    output logic [31:0]       tried_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SEND,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [16*LEN-1:0] r_cand;
    logic [16*LEN-1:0] r_end;
    logic [16*LEN-1:0] r_found_value;
    logic              r_found;
    logic [31:0]       r_tried;
    logic [1:0]        r_idx;
    logic [31:0]       r_wcnt;
    logic [16*LEN-1:0] w_shift;
    logic              w_last_word;
    logic              w_wait_end;

    assign w_last_word = (r_idx == 2'(LEN - 1));
    assign w_wait_end  = (r_wcnt == 32'(HIT_LAT - 2));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (start) w_next = S_CLEAR;
                S_CLEAR: w_next = S_SEND;
                S_SEND: begin
                    if (w_last_word) begin
                        w_next = (HIT_LAT == 1) ? S_CHECK : S_WAIT;
                    end
                end
                S_WAIT:  if (w_wait_end) w_next = S_CHECK;
                S_CHECK: begin
                    if (hit_in || (r_cand == r_end)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_CLEAR;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Abort freezes results; the state register alone returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cand        <= '0;
            r_end         <= '0;
            r_found       <= 1'b0;
            r_found_value <= '0;
            r_tried       <= '0;
            r_idx         <= '0;
            r_wcnt        <= '0;
        end else if (!abort) begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cand        <= start_value;
                        r_end         <= end_value;
                        r_found       <= 1'b0;
                        r_found_value <= '0;
                        r_tried       <= '0;
                    end
                end
                S_CLEAR: r_idx <= '0;
                S_SEND: begin
                    r_idx  <= r_idx + 2'd1;
                    r_wcnt <= '0;
                end
                S_WAIT:  r_wcnt <= r_wcnt + 32'd1;
                S_CHECK: begin
                    if (r_tried != 32'hFFFF_FFFF) begin
                        r_tried <= r_tried + 32'd1;
                    end
                    if (hit_in) begin
                        r_found       <= 1'b1;
                        r_found_value <= r_cand;
                    end else if (r_cand != r_end) begin
                        r_cand <= r_cand + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Most significant word goes out first.
    assign w_shift     = r_cand >> (16 * (LEN - 1 - 32'(r_idx)));
    assign mgmt_valid  = (r_state == S_CLEAR);
    assign mgmt_data   = 8'h00;
    assign in_valid    = (r_state == S_SEND);
    assign in_data     = in_valid ? w_shift[15:0] : 16'h0000;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign found       = r_found;
    assign found_value = r_found_value;
    assign tried_count = r_tried;

endmodule
